// File: rtl/tftlcd_pkg.sv
// Shared types and constants for the TFT LCD 8080-bus controller.
package tftlcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } state_t;

  localparam logic CMD  = 1'b0;
  localparam logic DATA = 1'b1;

  localparam int LCD_DATA_W = 16;

  // Queued bus operation at the default bus width.
  typedef struct packed {
    logic                  rd;
    logic                  dc;
    logic [LCD_DATA_W-1:0] data;
  } op_entry_t;

endpackage

// File: rtl/tftlcd_op_fifo.sv
// Single-clock operation FIFO with registered full/empty flags.
module tftlcd_op_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter int ENTRY_W    = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [ENTRY_W-1:0] wdata,
  output logic [ENTRY_W-1:0] rdata,
  output logic               full,
  output logic               empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wptr, rptr;
  logic [AW:0]        count, count_nxt;
  logic               push_ok, pop_ok;

  // A push while full is refused even if a pop frees a slot this cycle.
  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;
  assign count_nxt = count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  assign rdata     = mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop_ok)  rptr <= rptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == (AW+1)'(FIFO_DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/tftlcd_bus_ctrl.sv
// 8080-style TFT LCD bus sequencer: drains queued command/data/read
// operations onto CS#/RS/WR#/RD#/DB with programmable strobe timing.
module tftlcd_bus_ctrl
  import tftlcd_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_W     = 16,
  parameter int TIMING_W   = 8
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_dc,
  input  logic                in_rd,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [TIMING_W-1:0] cfg_t_low,
  input  logic [TIMING_W-1:0] cfg_t_high,
  output logic                rd_valid,
  output logic [DATA_W-1:0]   rd_data,
  output logic                busy,
  output logic                lcd_cs_n,
  output logic                lcd_rs,
  output logic                lcd_wr_n,
  output logic                lcd_rd_n,
  output logic [DATA_W-1:0]   lcd_db_o,
  output logic                lcd_db_oe,
  input  logic [DATA_W-1:0]   lcd_db_i
);

  typedef struct packed {
    logic              rd;
    logic              dc;
    logic [DATA_W-1:0] data;
  } entry_t;

  function automatic logic [TIMING_W-1:0] min1(input logic [TIMING_W-1:0] v);
    return (v == '0) ? TIMING_W'(1) : v;
  endfunction

  state_t              state, state_nxt;
  entry_t              cur, cur_nxt, fifo_out;
  logic [DATA_W+1:0]   fifo_rdata;
  logic                fifo_full, fifo_empty, pop, load, cap;
  logic [TIMING_W-1:0] cnt, cnt_nxt, t_low, t_low_nxt, t_high, t_high_nxt;
  logic                cs_nxt, rs_nxt, wr_nxt, rd_nxt, oe_nxt;
  logic [DATA_W-1:0]   db_nxt;

  tftlcd_op_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .ENTRY_W    (DATA_W + 2)
  ) u_fifo (
    .clk   (ACLK),
    .rst   (ARESET),
    .push  (in_valid),
    .pop   (pop),
    .wdata ({in_rd, in_dc, in_data}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign fifo_out = entry_t'(fifo_rdata);
  assign in_ready = !fifo_full;
  assign busy     = !fifo_empty || (state != ST_IDLE);

  always_comb begin
    state_nxt  = state;
    cur_nxt    = cur;
    cnt_nxt    = cnt;
    t_low_nxt  = t_low;
    t_high_nxt = t_high;
    cs_nxt     = lcd_cs_n;
    rs_nxt     = lcd_rs;
    wr_nxt     = lcd_wr_n;
    rd_nxt     = lcd_rd_n;
    oe_nxt     = lcd_db_oe;
    db_nxt     = lcd_db_o;
    pop        = 1'b0;
    load       = 1'b0;
    cap        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          load      = 1'b1;
          state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        cnt_nxt   = t_low;
        state_nxt = ST_STROBE;
        if (cur.rd) rd_nxt = 1'b0;
        else        wr_nxt = 1'b0;
      end
      ST_STROBE: begin
        if (cnt == TIMING_W'(1)) begin
          wr_nxt    = 1'b1;
          rd_nxt    = 1'b1;
          cap       = cur.rd;
          cnt_nxt   = t_high;
          state_nxt = ST_HOLD;
        end else begin
          cnt_nxt = cnt - TIMING_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt != TIMING_W'(1)) begin
          cnt_nxt = cnt - TIMING_W'(1);
        end else if (!fifo_empty) begin
          load      = 1'b1;
          state_nxt = ST_SETUP;
        end else begin
          cs_nxt    = 1'b1;
          oe_nxt    = 1'b0;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Timing is sampled only here, so cfg changes never disturb an operation in flight.
    if (load) begin
      pop        = 1'b1;
      cur_nxt    = fifo_out;
      t_low_nxt  = min1(cfg_t_low);
      t_high_nxt = min1(cfg_t_high);
      cs_nxt     = 1'b0;
      rs_nxt     = fifo_out.dc;
      oe_nxt     = !fifo_out.rd;
      if (!fifo_out.rd) db_nxt = fifo_out.data;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      cur       <= '0;
      cnt       <= '0;
      t_low     <= TIMING_W'(1);
      t_high    <= TIMING_W'(1);
      lcd_cs_n  <= 1'b1;
      lcd_rs    <= 1'b0;
      lcd_wr_n  <= 1'b1;
      lcd_rd_n  <= 1'b1;
      lcd_db_o  <= '0;
      lcd_db_oe <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      cur       <= cur_nxt;
      cnt       <= cnt_nxt;
      t_low     <= t_low_nxt;
      t_high    <= t_high_nxt;
      lcd_cs_n  <= cs_nxt;
      lcd_rs    <= rs_nxt;
      lcd_wr_n  <= wr_nxt;
      lcd_rd_n  <= rd_nxt;
      lcd_db_o  <= db_nxt;
      lcd_db_oe <= oe_nxt;
      rd_valid  <= cap;
      if (cap) rd_data <= lcd_db_i;
    end
  end

endmodule

// File: doc/tftlcd_bus_ctrl.md
Name: tftlcd_bus_ctrl

Overview:
- Downstream stage of the TFTLCD AXI4-Lite register slave. It takes command and data words, plus read requests, that the register file produces from slave-register writes.
- Buffers them in a small FIFO and drives an 8080-style parallel TFT LCD bus (CS#, RS, WR#, RD#, DB[15:0]) with programmable strobe timing.
- Read results return to the register file for software readback.

Parameters:
- FIFO_DEPTH, 8, number of queued bus operations; power of two, ≥2.
- DATA_W, 16, LCD data bus width.
- TIMING_W, 8, width of the strobe-timing configuration fields.

Ports:
- ACLK  in  1  system clock (AXI clock domain).
- ARESET  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation offered by the register file.
- in_ready  out  1  FIFO can accept; high when not full.
- in_dc  in  1  1 = data (RS high), 0 = command (RS low).
- in_rd  in  1  1 = bus read, 0 = bus write.
- in_data  in  DATA_W  write data; ignored for reads.
- cfg_t_low  in  TIMING_W  strobe-low duration in cycles; 0 is treated as 1.
- cfg_t_high  in  TIMING_W  strobe-high hold duration in cycles; 0 is treated as 1.
- rd_valid  out  1  one-cycle pulse when rd_data is updated.
- rd_data  out  DATA_W  last captured read word; held until the next read.
- busy  out  1  FIFO not empty or FSM not IDLE.
- lcd_cs_n  out  1  chip select, active low.
- lcd_rs  out  1  register select.
- lcd_wr_n  out  1  write strobe, active low.
- lcd_rd_n  out  1  read strobe, active low.
- lcd_db_o  out  DATA_W  bus output data.
- lcd_db_oe  out  1  output enable for the DB pad tristate.
- lcd_db_i  in  DATA_W  bus input data.

Behaviour:
- Reset values (asynchronous, on ARESET high):
  - lcd_cs_n = 1, lcd_wr_n = 1, lcd_rd_n = 1, lcd_rs = 0.
  - lcd_db_o = 0, lcd_db_oe = 0.
  - rd_valid = 0, rd_data = 0, busy = 0.
  - FIFO flushed, FSM in IDLE.
- Reset mid-transaction aborts immediately: strobes go high and queued entries are lost.
- Push side:
  - Push on in_valid && in_ready. The entry is {in_rd, in_dc, in_data}.
  - in_ready = !full, registered from FIFO state.
  - No combinational path from in_valid to any output.
- Push/pop rules:
  - A push and a pop in the same cycle are both allowed; the count is unchanged.
  - When full, a push is refused even if a pop occurs that cycle.
- All LCD outputs are registered.
- FSM states:
  - IDLE: if FIFO non-empty, pop; latch entry; latch cfg_t_low/cfg_t_high; assert cs_n=0; set rs=dc. For a write, drive db_o=data and db_oe=1; for a read, db_oe=0. Go to SETUP.
  - SETUP: exactly 1 cycle with strobes high (address/data setup). Then go to STROBE; assert wr_n=0 (write) or rd_n=0 (read).
  - STROBE: strobe low for max(t_low,1) cycles. On leaving, deassert the strobe. For a read, capture lcd_db_i into rd_data on that same edge and pulse rd_valid for one cycle. Go to HOLD.
  - HOLD: strobe high, data and RS held, for max(t_high,1) cycles. Then:
    - FIFO non-empty: pop, latch the new entry and timing, keep cs_n=0, go to SETUP (back-to-back, CS stays low).
    - FIFO empty: cs_n=1, db_oe=0, go to IDLE.
- Timing configuration is sampled only at entry pop; changing cfg mid-operation does not affect the operation in progress.
- Write latency: push accepted at edge E0 → cs_n low after E1 → wr_n low after E2 → wr_n high after E2+T_low.
  - Cycle length per back-to-back operation = 1 + T_low + T_high.
- Counter: a single TIMING_W down-counter reused by STROBE and HOLD. cfg = 255 gives 255 cycles; there is no wrap.
- Read vs write direction: db_oe is never 1 while rd_n = 0. Switching from a read to a write forces db_oe low through HOLD; the bus is redriven in SETUP.
- busy falls on the cycle cs_n returns high with the FIFO empty.

Decomposition:
- tftlcd_pkg:
  - FSM state enum (IDLE, SETUP, STROBE, HOLD).
  - FIFO entry struct {rd, dc, data}.
  - Constants CMD = 0, DATA = 1.
- Sub-module tftlcd_op_fifo: synchronous single-clock FIFO with registered full/empty and asynchronous reset, parameterised by FIFO_DEPTH and entry width.
- The top level holds the FSM, the timing counter and the LCD output registers.

Test Plan:
- Single write: reset, cfg_t_low=2, cfg_t_high=1; push dc=0, data=16'h002C at E0.
  → cs_n low after E1, rs=0, db_o=002C, db_oe=1; wr_n low for exactly 2 cycles from E2; cs_n high 1 cycle after wr_n rises; busy falls at the same time.
- Back-to-back burst: push cmd 16'h002C, then data 16'hF800, 16'h07E0, 16'h001F with t_low=1, t_high=1.
  → cs_n stays low throughout; 3 cycles per operation; rs sequence 0,1,1,1; db_o sequence matches the pushes.
- Read: push rd=1, dc=1; drive lcd_db_i=16'hA5C3 during the strobe; t_low=3.
  → rd_n low 3 cycles; db_oe=0 throughout; rd_valid pulses once with rd_data=A5C3.
- FIFO full: hold t_low=20 and push 10 writes back-to-back.
  → in_ready drops after FIFO_DEPTH entries are queued (first entry popped); all 9 accepted entries appear on the bus in order; refused pushes never appear.
- Zero timing and mid-operation config change: cfg_t_low=0 → strobe lasts 1 cycle. Change cfg_t_low from 4 to 1 during STROBE → current strobe stays 4 cycles, next strobe is 1 cycle.
- Reset mid-transaction: assert ARESET while wr_n=0 with 3 entries queued.
  → wr_n, cs_n and rd_n all high and db_oe=0 immediately (asynchronous); after release busy=0, in_ready=1, and no stale operation executes.
